// File: rtl/msa_scheduler.sv
// SHA-256 message-schedule expander: loads a 16-word block and iteratively
// extends it to the 64-word schedule, one new word per cycle, then holds it for the compressor.
module msa_scheduler (
  input  logic              clk,
  input  logic              rst,
  output logic              blk_rdy,
  input  logic              blk_vld,
  input  logic [15:0][31:0] blk,
  input  logic              w_rdy,
  output logic              w_vld,
  output logic [63:0][31:0] w
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    OUTPUT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [63:0][31:0] w_q;
  logic [31:0]       w_new;
  logic              accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign accept = blk_vld & blk_rdy;

  // Single sigma-adder chain; idx is always >= 16 while this result is used.
  always_comb begin
    w_new = sig1(w_q[idx_q - 6'd2]) + w_q[idx_q - 6'd7]
          + sig0(w_q[idx_q - 6'd15]) + w_q[idx_q - 6'd16];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXPAND;
          idx_d   = 6'd16;
        end
      end
      EXPAND: begin
        if (idx_q == 6'd63) begin
          state_d = OUTPUT;
        end else begin
          idx_d = idx_q + 6'd1;
        end
      end
      OUTPUT: begin
        if (w_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    blk_rdy = (state_q == IDLE) & rst;
    w_vld   = (state_q == OUTPUT);
  end

  // NOTE: the schedule array is reset deliberately: an aborted block must not
  // leave partial words visible on w after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
    end else if (accept) begin
      w_q[15:0] <= blk;
    end else if (state_q == EXPAND) begin
      w_q[idx_q] <= w_new;
    end
  end

  assign w = w_q;

endmodule

// File: tb/tb_msa_scheduler.sv
// Directed bench for msa_scheduler: table-driven blocks checked against a
// schedule model and hand-computed words, plus backpressure, reset and streaming sequences.
module tb_msa_scheduler;

  typedef logic [15:0][31:0] blk_t;
  typedef logic [63:0][31:0] sched_t;

  typedef struct {
    string       name;
    blk_t        blk;
    int          i0;
    logic [31:0] v0;
    int          i1;
    logic [31:0] v1;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              blk_rdy;
  logic              blk_vld;
  blk_t              blk;
  logic              w_rdy;
  logic              w_vld;
  sched_t            w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  msa_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .blk_rdy (blk_rdy),
    .blk_vld (blk_vld),
    .blk     (blk),
    .w_rdy   (w_rdy),
    .w_vld   (w_vld),
    .w       (w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x} >> n;
    return xx[31:0];
  endfunction

  function automatic sched_t model(input blk_t b);
    sched_t s;
    logic [31:0] s0, s1;
    s = '0;
    for (int i = 0; i < 16; i++) s[i] = b[i];
    for (int i = 16; i < 64; i++) begin
      s0   = m_rotr(s[i-15], 7) ^ m_rotr(s[i-15], 18) ^ (s[i-15] >> 3);
      s1   = m_rotr(s[i-2], 17) ^ m_rotr(s[i-2], 19) ^ (s[i-2] >> 10);
      s[i] = s1 + s[i-7] + s0 + s[i-16];
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_sched(input string nm, input sched_t exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int i = 63; i >= 0; i--) if (w[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: w[%0d] got %08h expected %08h", nm, bad, w[bad], exp[bad]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_blk_rdy(input string nm);
    int n;
    n = 0;
    while (!blk_rdy && n < 100) begin tick(); n++; end
    check({nm, "_blk_rdy_timeout"}, 64'(n < 100), 64'd1);
  endtask

  // Returns cycles from the accept edge until w_vld is observed (capped).
  task automatic wait_w_vld(output int n);
    n = 0;
    while (!w_vld && n < 100) begin tick(); n++; end
  endtask

  // Accepts one block with w_rdy high and checks latency, schedule and hand-off.
  task automatic run_block(input vec_t v);
    int     n;
    sched_t exp;
    exp = model(v.blk);
    wait_blk_rdy(v.name);
    blk     = v.blk;
    blk_vld = 1'b1;
    tick();
    blk_vld = 1'b0;
    blk     = '1;
    check({v.name, "_busy"}, {w_vld, blk_rdy}, 2'b00);
    wait_w_vld(n);
    check({v.name, "_latency"}, 64'(n), 64'd48);
    check_sched({v.name, "_sched"}, exp);
    check({v.name, "_word_a"}, w[v.i0], v.v0);
    check({v.name, "_word_b"}, w[v.i1], v.v1);
    tick();
    check({v.name, "_vld_pulse"}, w_vld, 1'b0);
    check({v.name, "_rdy_back"}, blk_rdy, 1'b1);
  endtask

  vec_t   vecs[3];
  blk_t   bb[4];
  sched_t exp_s;

  initial begin
    int n, acc, prev;

    vecs[0].name = "abc";
    vecs[0].blk  = '0;
    vecs[0].blk[0]  = 32'h61626380;
    vecs[0].blk[15] = 32'h00000018;
    vecs[0].i0 = 16; vecs[0].v0 = 32'h61626380;
    vecs[0].i1 = 17; vecs[0].v1 = 32'h000F0000;

    vecs[1].name = "zeros";
    vecs[1].blk  = '0;
    vecs[1].i0 = 16; vecs[1].v0 = 32'h00000000;
    vecs[1].i1 = 63; vecs[1].v1 = 32'h00000000;

    vecs[2].name = "ones";
    vecs[2].blk  = '1;
    vecs[2].i0 = 16; vecs[2].v0 = 32'h203FFFFC;
    vecs[2].i1 = 0;  vecs[2].v1 = 32'hFFFFFFFF;

    rst = 1'b0; blk_vld = 1'b0; blk = '0; w_rdy = 1'b1;
    #12;
    check("reset_blk_rdy", blk_rdy, 1'b0);
    check("reset_w_vld",   w_vld,   1'b0);
    check_sched("reset_w", '0);
    rst = 1'b1;
    tick();
    check("post_reset_blk_rdy", blk_rdy, 1'b1);

    for (int i = 0; i < 3; i++) run_block(vecs[i]);

    // Backpressure: schedule held while blk_vld/blk toggle.
    w_rdy = 1'b0;
    exp_s = model(vecs[2].blk);
    wait_blk_rdy("bp");
    blk = vecs[2].blk; blk_vld = 1'b1;
    tick();
    blk_vld = 1'b0;
    wait_w_vld(n);
    check("bp_latency", 64'(n), 64'd48);
    for (int i = 0; i < 10; i++) begin
      blk_vld = i[0];
      for (int j = 0; j < 16; j++) blk[j] = $urandom;
      tick();
      check_sched("bp_hold_w", exp_s);
      check("bp_hold_flags", {w_vld, blk_rdy}, 2'b10);
    end
    blk_vld = 1'b0;
    w_rdy   = 1'b1;
    tick();
    check("bp_release", {w_vld, blk_rdy}, 2'b01);
    check_sched("bp_release_w", exp_s);

    // Reset in the middle of expansion (idx == 30).
    wait_blk_rdy("rst");
    blk = vecs[0].blk; blk_vld = 1'b1;
    tick();
    blk_vld = 1'b0;
    repeat (14) tick();
    check("rst_pre_vld", w_vld, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_flags", {w_vld, blk_rdy}, 2'b00);
    check_sched("rst_w_cleared", '0);
    repeat (3) tick();
    check("rst_hold_flags", {w_vld, blk_rdy}, 2'b00);
    rst = 1'b1;
    #1;
    check("rst_release_rdy", blk_rdy, 1'b1);
    check_sched("rst_release_w", '0);
    run_block(vecs[0]);

    // Back-to-back streaming with blk_vld and w_rdy tied high.
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 16; j++) bb[k][j] = $urandom;
    prev = 0;
    blk = bb[0]; blk_vld = 1'b1; w_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_blk_rdy("b2b");
      @(posedge clk);
      #1;
      acc = cyc;
      blk = bb[(k < 3) ? k + 1 : k];
      if (k > 0) check("b2b_period", 64'(acc - prev), 64'd50);
      prev = acc;
      wait_w_vld(n);
      check("b2b_latency", 64'(n), 64'd48);
      check_sched("b2b_sched", model(bb[k]));
    end
    blk_vld = 1'b0;
    repeat (3) tick();
    check("final_idle", {w_vld, blk_rdy}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
